// File: rtl/sha_nonce_sequencer.sv
// Nonce sequencer for a pipelined SHA core: accepts a job, issues a
// contiguous run of nonces one per cycle, tracks in-flight slots and
// captures the first winning nonce reported by the core comparator.
module sha_nonce_sequencer #(
    parameter int PIPE_LATENCY = 64,
    parameter int NONCE_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   job_valid,
    output logic                   job_ready,
    input  logic [NONCE_WIDTH-1:0] job_nonce_start,
    input  logic [NONCE_WIDTH-1:0] job_nonce_count,
    input  logic                   abort,
    output logic                   core_issue,
    output logic [NONCE_WIDTH-1:0] core_nonce,
    input  logic                   core_hit,
    output logic                   hit_valid,
    input  logic                   hit_ready,
    output logic [NONCE_WIDTH-1:0] hit_nonce,
    output logic                   hit_overflow,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;

    logic [NONCE_WIDTH-1:0] next_nonce;
    logic [NONCE_WIDTH-1:0] remaining;
    logic [7:0]             drain_cnt;

    logic                   accept;
    logic                   issue;
    logic                   enter_drain;

    logic [PIPE_LATENCY-1:0] slot_valid;
    logic [NONCE_WIDTH-1:0]  slot_nonce [PIPE_LATENCY];

    logic                   slot_hit;
    logic                   hit_pop;
    logic                   hit_valid_q;
    logic [NONCE_WIDTH-1:0] hit_nonce_q;
    logic                   overflow_q;
    logic                   done_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; issue is decided here so it starts the cycle after acceptance and stops the cycle abort arrives.
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        issue       = 1'b0;
        enter_drain = 1'b0;
        case (state)
            IDLE: begin
                if (job_valid) begin
                    accept = 1'b1;
                    if (job_nonce_count == '0) begin
                        state_next  = DRAIN;
                        enter_drain = 1'b1;
                    end else begin
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (abort) begin
                    state_next  = DRAIN;
                    enter_drain = 1'b1;
                end else begin
                    issue = 1'b1;
                    if (remaining == NONCE_WIDTH'(1)) begin
                        state_next  = DRAIN;
                        enter_drain = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt == 8'd0) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Nonce generator and remaining-count tracking for the active job.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            next_nonce <= '0;
            remaining  <= '0;
        end else if (accept) begin
            next_nonce <= job_nonce_start;
            remaining  <= job_nonce_count;
        end else if (issue) begin
            next_nonce <= next_nonce + NONCE_WIDTH'(1);
            remaining  <= remaining - NONCE_WIDTH'(1);
        end
    end

    // DRAIN lasts exactly PIPE_LATENCY cycles, long enough for the last issued slot to reach the core output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain_cnt <= 8'd0;
        end else if (enter_drain) begin
            drain_cnt <= 8'(PIPE_LATENCY - 1);
        end else if (state == DRAIN && drain_cnt != 8'd0) begin
            drain_cnt <= drain_cnt - 8'd1;
        end
    end

    // One-cycle retirement pulse, aligned with the return to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (state == DRAIN) && (drain_cnt == 8'd0);
        end
    end

    // In-flight slot tracker mirroring the core pipeline; it never stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_valid <= '0;
            for (int i = 0; i < PIPE_LATENCY; i++) begin
                slot_nonce[i] <= '0;
            end
        end else begin
            for (int i = PIPE_LATENCY - 1; i > 0; i--) begin
                slot_valid[i] <= slot_valid[i-1];
                slot_nonce[i] <= slot_nonce[i-1];
            end
            slot_valid[0] <= issue;
            slot_nonce[0] <= next_nonce;
        end
    end

    assign slot_hit = slot_valid[PIPE_LATENCY-1] && core_hit;
    assign hit_pop  = hit_valid_q && hit_ready;

    // One-entry hit buffer; a hit arriving while it is full and not being drained is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_valid_q <= 1'b0;
            hit_nonce_q <= '0;
        end else if (slot_hit && (!hit_valid_q || hit_pop)) begin
            hit_valid_q <= 1'b1;
            hit_nonce_q <= slot_nonce[PIPE_LATENCY-1];
        end else if (hit_pop) begin
            hit_valid_q <= 1'b0;
        end
    end

    // Sticky overflow flag, cleared only when a new job is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (accept) begin
            overflow_q <= 1'b0;
        end else if (slot_hit && hit_valid_q && !hit_pop) begin
            overflow_q <= 1'b1;
        end
    end

    assign job_ready    = (state == IDLE);
    assign busy         = (state != IDLE);
    assign core_issue   = issue;
    assign core_nonce   = issue ? next_nonce : '0;
    assign hit_valid    = hit_valid_q;
    assign hit_nonce    = hit_nonce_q;
    assign hit_overflow = overflow_q;
    assign done         = done_q;

endmodule

// File: doc/sha_nonce_sequencer.md
SHA_NONCE_SEQUENCER -- requirements
Module: sha_nonce_sequencer

Interface
REQ-001 SHALL have parameter PIPE_LATENCY, default 64: cycles from core_issue to the matching core_hit sample; legal range 1..255.
REQ-002 SHALL have parameter NONCE_WIDTH, default 32: width of every nonce and count field.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port job_valid, input, 1 bit: a new job is offered.
REQ-006 SHALL have port job_ready, output, 1 bit: sequencer accepts a job this cycle.
REQ-007 SHALL have port job_nonce_start, input, NONCE_WIDTH: first nonce of the job.
REQ-008 SHALL have port job_nonce_count, input, NONCE_WIDTH: number of nonces to issue; 0 means an empty job.
REQ-009 SHALL have port abort, input, 1 bit: stop issuing the current job.
REQ-010 SHALL have port core_issue, output, 1 bit: core_nonce is valid and enters the pipelined SHA core this cycle.
REQ-011 SHALL have port core_nonce, output, NONCE_WIDTH: nonce driven into the core.
REQ-012 SHALL have port core_hit, input, 1 bit: comparator result at the core output; meaningful only in the slot tracked as valid.
REQ-013 SHALL have port hit_valid, output, 1 bit: a winning nonce is held.
REQ-014 SHALL have port hit_ready, input, 1 bit: consumer takes the held hit.
REQ-015 SHALL have port hit_nonce, output, NONCE_WIDTH: the winning nonce.
REQ-016 SHALL have port hit_overflow, output, 1 bit: sticky flag, a hit was dropped.
REQ-017 SHALL have port busy, output, 1 bit: high in ISSUE or DRAIN.
REQ-018 SHALL have port done, output, 1 bit: one-cycle pulse when a job fully retires.

Function
REQ-019 SHALL implement states IDLE, ISSUE and DRAIN; job_ready SHALL be 1 only in IDLE.
REQ-020 SHALL, on job_valid && job_ready, latch the start and count and move to ISSUE; a zero count SHALL go straight to DRAIN.
REQ-021 SHALL, in ISSUE, assert core_issue every cycle with nonces start, start+1, ... in order, wrapping modulo 2^NONCE_WIDTH, until count nonces are issued, then go to DRAIN.
REQ-022 SHALL drive core_issue combinationally from state and the remaining count, so issue begins the cycle after acceptance with no bubbles.
REQ-023 SHALL track in-flight slots with a PIPE_LATENCY-deep shift register of {valid, nonce} that shifts every cycle with no stall; the pipelined core has no enable.
REQ-024 SHALL treat core_hit as a hit only when the shift-register output slot is valid; the hit nonce SHALL be that slot's nonce.
REQ-025 SHALL, in DRAIN, go to IDLE and pulse done the cycle after the shift register holds no valid slot, so DRAIN lasts PIPE_LATENCY cycles after the last issue.
REQ-026 SHALL, on abort in ISSUE, deassert core_issue that same cycle and go to DRAIN; in-flight slots still retire and report hits; abort in IDLE or DRAIN SHALL be ignored.
REQ-027 SHALL hold one hit in a one-entry buffer: load on a valid hit when empty, or when emptied the same cycle by hit_valid && hit_ready.
REQ-028 SHALL, on a valid hit while the buffer is full and not draining, drop the new hit, keep the held one, and set hit_overflow.
REQ-029 SHALL clear hit_overflow only on the cycle a new job is accepted.
REQ-030 SHALL NOT let hit handshakes block job acceptance; a held hit persists across jobs.

Reset
REQ-031 SHALL, when rst is asserted, immediately go to IDLE, clear all shift-register valid bits, the hit buffer and hit_overflow, and drive job_ready=1 and every other output, data included, to 0.
REQ-032 SHALL ignore in-flight core_hit after reset mid-job, because the valid bits are cleared.

Verification
REQ-033 Test: start=0x10, count=4, no hits, PIPE_LATENCY=4 -> core_nonce 0x10..0x13 on 4 consecutive cycles; done pulses 5 cycles after the last issue; busy falls with it.
REQ-034 Test: start=0xFFFFFFFE, count=3 -> nonces 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
REQ-035 Test: core_hit high in the slot of nonce 0x12 -> hit_valid with hit_nonce=0x12, held until hit_ready; core_hit in an invalid slot -> no hit.
REQ-036 Test: hit_ready=0 with hits on 0x11 and 0x13 -> hit_nonce stays 0x11 and hit_overflow=1 until the next job is accepted.
REQ-037 Test: count=100, abort on the 3rd issue cycle -> exactly 2 nonces issued, done after drain; a zero-count job -> no issue, done after PIPE_LATENCY+1 cycles.
REQ-038 Test: rst asserted mid-ISSUE with hits in flight -> all outputs 0 and job_ready=1 at once; no hit_valid afterwards.
